// File: rtl/mm_burst_master_if.sv
// Memory-mapped bus bundle between the burst master and a slave/memory model.
// The master drives the command side; the slave returns waitrequest and read data.
interface mm_burst_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address, write, writedata, read,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, write, writedata, read,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/mm_burst_master.sv
// Burst traffic master: writes BURST_LEN counting words from a base address.
// Define MM_MASTER_VERIFY_EN to build the read-back phase and mismatch counter.
//
// state  | meaning
// IDLE   | waiting for start
// WGAP   | idle bus cycles before a write
// WR     | write command on the bus
// RGAP   | idle bus cycles before a read
// RD     | read command on the bus
// RWAIT  | read accepted, waiting for readdatavalid
// DONE   | one-cycle completion pulse
module mm_burst_master #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int BURST_LEN  = 16,
  parameter int GAP_CYCLES = 1,
  parameter int DATA_SEED  = 0,
  parameter int IDLE_FILL  = 99
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  mm_burst_master_if.master bus,
  output logic              busy_o,
  output logic              done_o,
  output logic [7:0]        err_cnt_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WGAP  = 3'd1;
  localparam logic [2:0] S_WR    = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
`ifdef MM_MASTER_VERIFY_EN
  localparam logic [2:0] S_RGAP  = 3'd4;
  localparam logic [2:0] S_RD    = 3'd5;
  localparam logic [2:0] S_RWAIT = 3'd6;
`endif

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] FILL_A   = ADDR_W'(IDLE_FILL);
  localparam logic [DATA_W-1:0] FILL_D   = DATA_W'(IDLE_FILL);
  localparam logic [2:0] WR_ENTRY = (GAP_CYCLES > 0) ? S_WGAP : S_WR;
`ifdef MM_MASTER_VERIFY_EN
  localparam logic [2:0] RD_ENTRY = (GAP_CYCLES > 0) ? S_RGAP : S_RD;
`endif

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [ADDR_W-1:0] addr_cur;
  logic [DATA_W-1:0] pattern;
  logic              wr_act;
  logic              rd_act;
  logic              last_idx;

  assign addr_cur = base_q + idx_q;
  assign pattern  = DATA_W'(idx_q) + DATA_W'(DATA_SEED);
  assign last_idx = (idx_q == IDX_LAST);

`ifdef MM_MASTER_VERIFY_EN
  logic [7:0] err_q, err_d;
`else
  logic unused_rd;
  assign unused_rd = ^{bus.readdata, bus.readdatavalid};
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    gap_d   = gap_q;
`ifdef MM_MASTER_VERIFY_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          base_d  = base_addr_i;
          idx_d   = '0;
          gap_d   = GAP_LOAD;
`ifdef MM_MASTER_VERIFY_EN
          err_d   = '0;
`endif
          state_d = WR_ENTRY;
        end
      end
      S_WGAP: begin
        if (gap_q == '0) state_d = S_WR;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      S_WR: begin
        if (!bus.waitrequest) begin
          gap_d = GAP_LOAD;
          if (last_idx) begin
            idx_d   = '0;
`ifdef MM_MASTER_VERIFY_EN
            state_d = RD_ENTRY;
`else
            state_d = S_DONE;
`endif
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = WR_ENTRY;
          end
        end
      end
`ifdef MM_MASTER_VERIFY_EN
      S_RGAP: begin
        if (gap_q == '0) state_d = S_RD;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      S_RD: begin
        if (!bus.waitrequest) state_d = S_RWAIT;
      end
      S_RWAIT: begin
        // Only one read is ever outstanding, so any valid here belongs to idx_q.
        if (bus.readdatavalid) begin
          if ((bus.readdata != pattern) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
          gap_d = GAP_LOAD;
          if (last_idx) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = RD_ENTRY;
          end
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      gap_q   <= '0;
`ifdef MM_MASTER_VERIFY_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      gap_q   <= gap_d;
`ifdef MM_MASTER_VERIFY_EN
      err_q   <= err_d;
`endif
    end
  end

  assign wr_act = (state_q == S_WR);
`ifdef MM_MASTER_VERIFY_EN
  assign rd_act    = (state_q == S_RD);
  assign err_cnt_o = err_q;
`else
  assign rd_act    = 1'b0;
  assign err_cnt_o = 8'd0;
`endif

  // Command outputs decode straight from state so waitrequest holds them stable.
  assign bus.write     = wr_act;
  assign bus.read      = rd_act;
  assign bus.address   = (wr_act || rd_act) ? addr_cur : FILL_A;
  assign bus.writedata = (wr_act || rd_act) ? pattern  : FILL_D;

  assign busy_o = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_mm_burst_master.sv
// Bench for mm_burst_master: two instances (GAP=1/LEN=4/SEED=0 and GAP=0/LEN=8/SEED=5)
// checked every cycle against a transfer-level model, plus literal scenario checks.
module tb_mm_burst_master;

`ifdef MM_MASTER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int FILL = 99;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start   [2];
  logic [7:0] base_in [2];
  logic       wreq    [2];
  logic       rdv     [2];
  logic [7:0] rdata   [2];
  logic       s_wr [2], s_rd [2], s_busy [2], s_done [2];
  logic [7:0] s_addr [2], s_wdata [2], s_err [2];

  mm_burst_master_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
  mm_burst_master_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

  assign bus0.waitrequest   = wreq[0];
  assign bus0.readdatavalid = rdv[0];
  assign bus0.readdata      = rdata[0];
  assign bus1.waitrequest   = wreq[1];
  assign bus1.readdatavalid = rdv[1];
  assign bus1.readdata      = rdata[1];
  assign s_wr[0] = bus0.write;   assign s_rd[0] = bus0.read;
  assign s_addr[0] = bus0.address; assign s_wdata[0] = bus0.writedata;
  assign s_wr[1] = bus1.write;   assign s_rd[1] = bus1.read;
  assign s_addr[1] = bus1.address; assign s_wdata[1] = bus1.writedata;

  mm_burst_master #(.ADDR_W(8), .DATA_W(8), .BURST_LEN(4), .GAP_CYCLES(1),
                    .DATA_SEED(0), .IDLE_FILL(99)) dut0 (
    .clk_i(clk), .reset_i(reset), .start_i(start[0]), .base_addr_i(base_in[0]),
    .bus(bus0), .busy_o(s_busy[0]), .done_o(s_done[0]), .err_cnt_o(s_err[0]));

  mm_burst_master #(.ADDR_W(8), .DATA_W(8), .BURST_LEN(8), .GAP_CYCLES(0),
                    .DATA_SEED(5), .IDLE_FILL(99)) dut1 (
    .clk_i(clk), .reset_i(reset), .start_i(start[1]), .base_addr_i(base_in[1]),
    .bus(bus1), .busy_o(s_busy[1]), .done_o(s_done[1]), .err_cnt_o(s_err[1]));

  function automatic int len_of(input int d);  return (d == 0) ? 4 : 8; endfunction
  function automatic int gap_of(input int d);  return (d == 0) ? 1 : 0; endfunction
  function automatic int seed_of(input int d); return (d == 0) ? 0 : 5; endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Transfer-level model state
  bit         mon_en = 1'b0;
  bit         act [2], dn [2], in_x [2], wresp [2];
  int         wc [2], rc [2], idle [2], err_m [2];
  logic [7:0] bm [2];
  // Observation logs used by the literal scenario checks
  int         done_cnt [2], run_cur [2], run_max [2], probe_cnt [2], wl_n [2];
  logic [7:0] probe_addr [2];
  logic [7:0] wl_addr [2][64];
  logic [7:0] wl_data [2][64];

  task automatic mon(input int d);
    int L, G, S;
    logic strobe;
    logic [7:0] exp_d;
    L = len_of(d); G = gap_of(d); S = seed_of(d);
    strobe = s_wr[d] | s_rd[d];
    chk("wr_rd_excl", 32'(s_wr[d] & s_rd[d]), 32'(0));
    chk("busy", 32'(s_busy[d]), 32'(act[d]));
    chk("done", 32'(s_done[d]), 32'(dn[d]));
    chk("err_cnt", 32'(s_err[d]), 32'(err_m[d]));
`ifndef MM_MASTER_VERIFY_EN
    chk("rd_tied", 32'(s_rd[d]), 32'(0));
`endif
    if (!strobe) begin
      chk("idle_addr", 32'(s_addr[d]), 32'(FILL));
      chk("idle_wdata", 32'(s_wdata[d]), 32'(FILL));
    end
    if (s_wr[d]) begin
      chk("wr_in_burst", 32'(act[d] && wc[d] < L), 32'(1));
      chk("wr_addr", 32'(s_addr[d]), 32'((bm[d] + wc[d]) % 256));
      chk("wr_data", 32'(s_wdata[d]), 32'((wc[d] + S) % 256));
    end
    if (s_rd[d]) begin
      chk("rd_after_writes", 32'(act[d] && wc[d] == L && rc[d] < L), 32'(1));
      chk("rd_addr", 32'(s_addr[d]), 32'((bm[d] + rc[d]) % 256));
    end
    if (strobe && !in_x[d]) begin
      chk("gap_len", 32'(idle[d]), 32'(G));
      in_x[d] = 1'b1;
    end
    if (act[d] && !strobe && !wresp[d]) begin
      idle[d]++;
      chk("stall", 32'(idle[d] > G), 32'(0));
    end
    if (s_wr[d] && s_addr[d] == probe_addr[d]) probe_cnt[d]++;
    if (s_wr[d]) begin
      run_cur[d]++;
      if (run_cur[d] > run_max[d]) run_max[d] = run_cur[d];
    end else run_cur[d] = 0;
    if (s_done[d]) done_cnt[d]++;

    // Effects of the coming clock edge
    if (reset) begin
      act[d] = 0; dn[d] = 0; in_x[d] = 0; wresp[d] = 0;
      wc[d] = 0; rc[d] = 0; idle[d] = 0; err_m[d] = 0;
    end else if (dn[d]) begin
      dn[d] = 0;
    end else if (!act[d]) begin
      if (start[d]) begin
        act[d] = 1; bm[d] = base_in[d]; wc[d] = 0; rc[d] = 0;
        err_m[d] = 0; idle[d] = 0; in_x[d] = 0; wresp[d] = 0;
      end
    end else begin
      if (wresp[d] && rdv[d]) begin
        exp_d = 8'((rc[d] - 1 + S) % 256);
        if (rdata[d] != exp_d && err_m[d] < 255) err_m[d]++;
        wresp[d] = 0; idle[d] = 0;
        if (rc[d] == L) begin act[d] = 0; dn[d] = 1; end
      end
      if (s_rd[d] && !wreq[d]) begin
        wresp[d] = 1; rc[d]++; in_x[d] = 0;
      end
      if (s_wr[d] && !wreq[d]) begin
        if (wl_n[d] < 64) begin
          wl_addr[d][wl_n[d]] = s_addr[d];
          wl_data[d][wl_n[d]] = s_wdata[d];
          wl_n[d]++;
        end
        wc[d]++; in_x[d] = 0; idle[d] = 0;
        if (wc[d] == L && !VERIFY) begin act[d] = 0; dn[d] = 1; end
      end
    end
  endtask

  always @(negedge clk) if (mon_en) for (int d = 0; d < 2; d++) mon(d);

  // Slave / memory model
  logic [7:0] mem [2][256];
  bit         pend [2], wrand [2], corr_en [2];
  bit         spur_en = 1'b1;
  int         lat [2];
  logic [7:0] rd_addr_p [2], corr_addr [2];
  bit         sw_acc [2], sr_acc [2], s_rst;
  logic [7:0] sa [2], sd [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      wreq[d] = 0; rdv[d] = 0; rdata[d] = 0; pend[d] = 0;
    end
    forever begin
      @(negedge clk);
      s_rst = reset;
      for (int d = 0; d < 2; d++) begin
        sw_acc[d] = s_wr[d] && !wreq[d];
        sr_acc[d] = s_rd[d] && !wreq[d];
        sa[d] = s_addr[d]; sd[d] = s_wdata[d];
      end
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (s_rst) pend[d] = 0;
        if (sw_acc[d]) mem[d][sa[d]] = sd[d];
        if (sr_acc[d]) begin
          pend[d] = 1; lat[d] = $urandom_range(0, 2); rd_addr_p[d] = sa[d];
        end
        if (pend[d] && lat[d] == 0) begin
          rdv[d] = 1; pend[d] = 0;
          rdata[d] = mem[d][rd_addr_p[d]] ^ ((corr_en[d] && rd_addr_p[d] == corr_addr[d]) ? 8'h5A : 8'h00);
        end else if (pend[d]) begin
          lat[d]--; rdv[d] = 0;
        end else begin
          rdv[d] = spur_en && ($urandom_range(0, 3) == 0);
          rdata[d] = 8'($urandom);
        end
        if (wrand[d]) wreq[d] = ($urandom_range(0, 2) == 0);
      end
    end
  end

  task automatic clear_log(input int d);
    wl_n[d] = 0; done_cnt[d] = 0; run_cur[d] = 0; run_max[d] = 0; probe_cnt[d] = 0;
  endtask

  task automatic run_burst(input int d, input logic [7:0] b);
    start[d] = 1; base_in[d] = b;
    @(posedge clk); #1;
    start[d] = 0;
  endtask

  task automatic wait_done(input int d, input int budget);
    int n = 0;
    while (!s_done[d] && n < budget) begin @(posedge clk); #1; n++; end
    chk("done_timeout", 32'(s_done[d]), 32'(1));
  endtask

  task automatic wait_both(input int budget);
    bit s0 = 0, s1 = 0;
    int n = 0;
    while (!(s0 && s1) && n < budget) begin
      @(posedge clk); #1; n++;
      if (s_done[0]) s0 = 1;
      if (s_done[1]) s1 = 1;
    end
    chk("both_done_timeout", 32'({s0, s1}), 32'(3));
  endtask

  initial begin
    int n;
    reset = 1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 0; base_in[d] = 0; wrand[d] = 0; corr_en[d] = 0;
      corr_addr[d] = 0; probe_addr[d] = 0; clear_log(d);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_write", 32'(s_wr[d]), 32'(0));
      chk("rst_addr", 32'(s_addr[d]), 32'(99));
      chk("rst_wdata", 32'(s_wdata[d]), 32'(99));
      chk("rst_busy", 32'(s_busy[d]), 32'(0));
      chk("rst_done", 32'(s_done[d]), 32'(0));
      chk("rst_err", 32'(s_err[d]), 32'(0));
    end
    mon_en = 1;
    @(posedge clk); #1;
    reset = 0;
    repeat (2) @(posedge clk);
    #1;

    // Basic burst at 0x10, with first-write latency GAP+1
    clear_log(0);
    run_burst(0, 8'h10);
    chk("t1_lat_gap", 32'(s_wr[0]), 32'(0));
    @(posedge clk); #1;
    chk("t1_lat_write", 32'(s_wr[0]), 32'(1));
    chk("t1_first_addr", 32'(s_addr[0]), 32'(8'h10));
    wait_done(0, 200);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_count", 32'(wl_n[0]), 32'(4));
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", 32'(wl_addr[0][i]), 32'(8'h10 + i));
      chk("t1_data", 32'(wl_data[0][i]), 32'(i));
    end
    chk("t1_done_pulses", 32'(done_cnt[0]), 32'(1));
    chk("t1_busy_low", 32'(s_busy[0]), 32'(0));

    // Waitrequest held for three cycles on the second write
    clear_log(0);
    probe_addr[0] = 8'h41;
    run_burst(0, 8'h40);
    n = 0;
    do begin @(negedge clk); n++; end while (!(s_wr[0] && s_addr[0] == 8'h40) && n < 50);
    chk("t2_first_write_seen", 32'(s_wr[0] && s_addr[0] == 8'h40), 32'(1));
    @(posedge clk); #1;
    wreq[0] = 1;
    repeat (4) @(posedge clk);
    #1;
    wreq[0] = 0;
    wait_done(0, 200);
    repeat (2) @(posedge clk);
    #1;
    chk("t2_hold_cycles", 32'(probe_cnt[0]), 32'(4));
    chk("t2_count", 32'(wl_n[0]), 32'(4));
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", 32'(wl_addr[0][i]), 32'(8'h40 + i));
      chk("t2_data", 32'(wl_data[0][i]), 32'(i));
    end

    // Address wrap with back-to-back writes (GAP=0 instance)
    clear_log(1);
    run_burst(1, 8'hFE);
    wait_done(1, 300);
    repeat (2) @(posedge clk);
    #1;
    chk("t3_count", 32'(wl_n[1]), 32'(8));
    for (int i = 0; i < 8; i++) begin
      chk("t3_addr", 32'(wl_addr[1][i]), 32'((254 + i) % 256));
      chk("t3_data", 32'(wl_data[1][i]), 32'(i + 5));
    end
    chk("t3_write_run", 32'(run_max[1]), 32'(8));

    // Read-back with word idx 2 corrupted by the memory
    clear_log(0);
    corr_en[0] = 1; corr_addr[0] = 8'h22; wrand[0] = 1;
    run_burst(0, 8'h20);
    wait_done(0, 400);
    chk("t4_err_cnt", 32'(s_err[0]), 32'(VERIFY ? 1 : 0));
    @(posedge clk); #1;
    wrand[0] = 0; wreq[0] = 0; corr_en[0] = 0;
    chk("t4_err_hold", 32'(s_err[0]), 32'(VERIFY ? 1 : 0));
    repeat (3) @(posedge clk);
    #1;

    // Reset during the write of idx 5
    wrand[1] = 1;
    run_burst(1, 8'h80);
    n = 0;
    while (!(s_wr[1] && s_addr[1] == 8'h85) && n < 300) begin @(posedge clk); #1; n++; end
    chk("t5_idx5_seen", 32'(s_wr[1] && s_addr[1] == 8'h85), 32'(1));
    reset = 1;
    @(posedge clk); #1;
    chk("t5_write", 32'(s_wr[1]), 32'(0));
    chk("t5_addr", 32'(s_addr[1]), 32'(99));
    chk("t5_busy", 32'(s_busy[1]), 32'(0));
    chk("t5_done", 32'(s_done[1]), 32'(0));
    reset = 0;
    wrand[1] = 0; wreq[1] = 0;
    @(posedge clk); #1;
    clear_log(1);
    run_burst(1, 8'h80);
    wait_done(1, 300);
    chk("t5_restart_count", 32'(wl_n[1]), 32'(8));
    chk("t5_restart_addr", 32'(wl_addr[1][0]), 32'(8'h80));
    chk("t5_restart_data", 32'(wl_data[1][0]), 32'(5));
    repeat (2) @(posedge clk);
    #1;

    // Start held high while busy and through the done cycle
    clear_log(0);
    run_burst(0, 8'h30);
    chk("t6_err_cleared", 32'(s_err[0]), 32'(0));
    n = 0;
    while (!s_done[0] && n < 300) begin
      start[0] = 1; base_in[0] = 8'h60;
      @(posedge clk); #1; n++;
    end
    chk("t6_done_seen", 32'(s_done[0]), 32'(1));
    @(posedge clk); #1;
    start[0] = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_done_pulses", 32'(done_cnt[0]), 32'(1));
    chk("t6_count", 32'(wl_n[0]), 32'(4));
    chk("t6_first_addr", 32'(wl_addr[0][0]), 32'(8'h30));
    chk("t6_busy_low", 32'(s_busy[0]), 32'(0));

    // Randomised bursts on both instances
    for (int it = 0; it < 8; it++) begin
      for (int d = 0; d < 2; d++) begin
        wrand[d] = 1;
        corr_en[d] = ($urandom_range(0, 1) == 1);
        base_in[d] = 8'($urandom);
        corr_addr[d] = base_in[d] + 8'($urandom_range(0, len_of(d) - 1));
        start[d] = 1;
      end
      @(posedge clk); #1;
      start[0] = 0; start[1] = 0;
      wait_both(800);
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #1;
    end
    wrand[0] = 0; wrand[1] = 0; wreq[0] = 0; wreq[1] = 0;
    repeat (5) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
